// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and defaults for the 64-bit RISC-V core
//               back end. Holds the default datapath widths, the
//               MEM/WB skid-register state encoding and the writeback
//               payload layout.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Default datapath and register-index widths for the core.
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Occupancy of the MEM/WB skid register.
    //   EMPTY : nothing held
    //   ONE   : main entry valid, skid empty
    //   TWO   : main and skid entries both valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_t;

    // One retiring instruction as held by the MEM/WB register, at the
    // core's default widths. Field order is the layout every instance
    // uses for its main and skid entries.
    typedef struct packed {
        logic [XLEN-1:0]       readdata;
        logic [XLEN-1:0]       aluresult;
        logic [XLEN-1:0]       wb_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  memtoreg;
        logic                  regwrite;
    } wb_payload_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments on every clock where enable is
//               high and sticks at all-ones instead of wrapping.
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous, active-high clear to zero
//               enable - count this cycle
//               count  - current count value (CNT_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_wb_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_skid_reg
// Description : MEM/WB pipeline register with a valid/ready handshake and a
//               2-entry (main + skid) buffer so back-pressure from the
//               writeback consumer never drops a retiring instruction.
//               Also provides synchronous flush, x0 write suppression, a
//               registered writeback-mux result and a saturating stall
//               counter.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               flush             - synchronous kill of all held entries
//               in_valid/in_ready - upstream handshake (in_ready is a flop)
//               in_*              - MEM-stage payload fields
//               out_valid/out_ready - downstream handshake
//               out_*             - registered main-entry payload
//               out_wb_data       - registered memtoreg ? readdata : aluresult
//               stall_cycles      - saturating count of stalled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_skid_reg #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_read_data,
    input  logic [XLEN-1:0]       in_aluresult,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_memtoreg,
    input  logic                  in_regwrite,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_readdata,
    output logic [XLEN-1:0]       out_aluresult,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_memtoreg,
    output logic                  out_regwrite,
    output logic [XLEN-1:0]       out_wb_data,
    output logic [CNT_W-1:0]      stall_cycles
);

    import core_pkg::*;

    // Same field layout as core_pkg::wb_payload_t, sized for this instance
    // so non-default XLEN / REG_ADDR_W builds keep a single-register entry.
    typedef struct packed {
        logic [XLEN-1:0]       readdata;
        logic [XLEN-1:0]       aluresult;
        logic [XLEN-1:0]       wb_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  memtoreg;
        logic                  regwrite;
    } payload_t;

    wb_state_t r_state;
    wb_state_t w_state_next;
    payload_t  r_main;
    payload_t  r_skid;
    payload_t  w_in_payload;
    logic      r_in_ready;
    logic      w_load_main_in;
    logic      w_load_main_skid;
    logic      w_load_skid;
    logic      w_stall;

    // ------------------------------------------------------------------
    // Capture formatting: the writeback mux is resolved here so that
    // out_wb_data comes straight from a flop, and writes to x0 are masked
    // before they are ever stored.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_payload           = '0;
        w_in_payload.readdata  = in_read_data;
        w_in_payload.aluresult = in_aluresult;
        w_in_payload.wb_data   = in_memtoreg ? in_read_data : in_aluresult;
        w_in_payload.rd        = in_rd;
        w_in_payload.memtoreg  = in_memtoreg;
        w_in_payload.regwrite  = in_regwrite && (in_rd != '0);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load-enable decode. in_ready is 1 in EMPTY and ONE,
    // so in those states in_valid alone means an accept. In ONE, a fire
    // together with an accept refills main directly (pass-through) rather
    // than parking the new entry in the skid.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            // Flush drops everything, including an input offered this cycle.
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (in_valid) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ONE;
                    end
                end
                ONE: begin
                    if (out_ready && in_valid) begin
                        w_load_main_in = 1'b1;
                    end else if (out_ready) begin
                        w_state_next = EMPTY;
                    end else if (in_valid) begin
                        w_load_skid  = 1'b1;
                        w_state_next = TWO;
                    end
                end
                TWO: begin
                    // Upstream is blocked (in_ready=0); only draining moves us.
                    if (out_ready) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ONE;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload registers. Main is only rewritten when it is empty or being
    // consumed, so its fields stay stable while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_payload;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_payload;
            end
        end
    end

    // in_ready is registered from the next state so it tracks
    // (state != TWO) without a combinational path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_next != TWO);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready      = r_in_ready;
    assign out_valid     = (r_state != EMPTY);
    assign out_readdata  = r_main.readdata;
    assign out_aluresult = r_main.aluresult;
    assign out_wb_data   = r_main.wb_data;
    assign out_rd        = r_main.rd;
    assign out_memtoreg  = r_main.memtoreg;
    assign out_regwrite  = r_main.regwrite;

    // ------------------------------------------------------------------
    // Back-pressure stall counter; flush intentionally leaves it alone.
    // ------------------------------------------------------------------
    assign w_stall = out_valid && !out_ready;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (w_stall),
        .count  (stall_cycles)
    );

endmodule : mem_wb_skid_reg
`default_nettype wire

// File: tb/tb_mem_wb_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_skid_reg
// Description : Self-checking bench for mem_wb_skid_reg: table of streaming
//               vectors plus hand-written back-pressure, flush, async-reset
//               and counter-saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_read_data;
    logic [63:0] in_aluresult;
    logic [4:0]  in_rd;
    logic        in_memtoreg;
    logic        in_regwrite;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_readdata;
    logic [63:0] out_aluresult;
    logic [4:0]  out_rd;
    logic        out_memtoreg;
    logic        out_regwrite;
    logic [63:0] out_wb_data;
    logic [15:0] stall_cycles;

    // Second instance with a narrow counter for the saturation check.
    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [63:0] out_readdata2;
    logic [63:0] out_aluresult2;
    logic [4:0]  out_rd2;
    logic        out_memtoreg2;
    logic        out_regwrite2;
    logic [63:0] out_wb_data2;
    logic [3:0]  stall_cycles2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_read_data  (in_read_data),
        .in_aluresult  (in_aluresult),
        .in_rd         (in_rd),
        .in_memtoreg   (in_memtoreg),
        .in_regwrite   (in_regwrite),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_readdata  (out_readdata),
        .out_aluresult (out_aluresult),
        .out_rd        (out_rd),
        .out_memtoreg  (out_memtoreg),
        .out_regwrite  (out_regwrite),
        .out_wb_data   (out_wb_data),
        .stall_cycles  (stall_cycles)
    );

    mem_wb_skid_reg #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk           (clk),
        .reset         (rst),
        .flush         (1'b0),
        .in_valid      (in_valid2),
        .in_ready      (in_ready2),
        .in_read_data  (64'h0),
        .in_aluresult  (64'h77),
        .in_rd         (5'd9),
        .in_memtoreg   (1'b0),
        .in_regwrite   (1'b1),
        .out_valid     (out_valid2),
        .out_ready     (out_ready2),
        .out_readdata  (out_readdata2),
        .out_aluresult (out_aluresult2),
        .out_rd        (out_rd2),
        .out_memtoreg  (out_memtoreg2),
        .out_regwrite  (out_regwrite2),
        .out_wb_data   (out_wb_data2),
        .stall_cycles  (stall_cycles2)
    );

    typedef struct {
        logic        v;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        m;
        logic        rw;
        logic        ordy;
        logic        e_valid;
        logic        e_in_ready;
        logic        chk_data;
        logic [63:0] e_wb;
        logic [63:0] e_alu;
        logic [63:0] e_rdata;
        logic [4:0]  e_rd;
        logic        e_rw;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] rdata, input logic [63:0] alu,
                         input logic [4:0] rd, input logic m, input logic rw, input logic ordy);
        in_valid     = v;
        in_read_data = rdata;
        in_aluresult = alu;
        in_rd        = rd;
        in_memtoreg  = m;
        in_regwrite  = rw;
        out_ready    = ordy;
    endtask

    // Apply current inputs across one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 64'h0, 64'h10, 5'd5, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 64'h10, 64'h10, 64'h0, 5'd5, 1'b1};
        vecs[1] = '{1'b1, 64'hDEAD_BEEF, 64'h40, 5'd7, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF, 64'h40, 64'hDEAD_BEEF, 5'd7, 1'b1};
        vecs[2] = '{1'b1, 64'h0, 64'h55, 5'd0, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 64'h55, 64'h55, 64'h0, 5'd0, 1'b0};
        vecs[3] = '{1'b1, 64'h99, 64'h1234, 5'd31, 1'b0, 1'b0, 1'b1,
                    1'b1, 1'b1, 1'b1, 64'h1234, 64'h1234, 64'h99, 5'd31, 1'b0};
        vecs[4] = '{1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 5'd0, 1'b0};
        vecs[5] = '{1'b1, 64'h1, 64'hAAAA_5555_0000_FFFF, 5'd3, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 64'hAAAA_5555_0000_FFFF, 64'hAAAA_5555_0000_FFFF,
                    64'h1, 5'd3, 1'b1};

        rst        = 1'b1;
        flush      = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        #23;
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_wb_data", out_wb_data, 64'h0);
        chk("rst_aluresult", out_aluresult, 64'h0);
        chk("rst_rd_rw", {58'h0, out_rd, out_regwrite}, 64'h0);
        chk("rst_stall", {48'h0, stall_cycles}, 64'h0);

        // Streaming table at full throughput
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].v, vecs[i].rdata, vecs[i].alu, vecs[i].rd,
                  vecs[i].m, vecs[i].rw, vecs[i].ordy);
            tick();
            chk($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d_in_ready", i), {63'h0, in_ready}, {63'h0, vecs[i].e_in_ready});
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_wb", i), out_wb_data, vecs[i].e_wb);
                chk($sformatf("vec%0d_alu", i), out_aluresult, vecs[i].e_alu);
                chk($sformatf("vec%0d_rdata", i), out_readdata, vecs[i].e_rdata);
                chk($sformatf("vec%0d_rd", i), {59'h0, out_rd}, {59'h0, vecs[i].e_rd});
                chk($sformatf("vec%0d_rw", i), {63'h0, out_regwrite}, {63'h0, vecs[i].e_rw});
            end
        end
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("drain_valid", {63'h0, out_valid}, 64'h0);
        chk("stream_stall", {48'h0, stall_cycles}, 64'h0);

        // Back-pressure: A, B, C with out_ready low
        drive(1'b1, 64'h0, 64'hA, 5'd1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bp_A_main", out_wb_data, 64'hA);
        chk("bp_A_in_ready", {63'h0, in_ready}, 64'h1);
        drive(1'b1, 64'h0, 64'hB, 5'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bp_B_in_ready", {63'h0, in_ready}, 64'h0);
        chk("bp_B_main_holds_A", out_wb_data, 64'hA);
        drive(1'b1, 64'h0, 64'hC, 5'd3, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bp_C_held_in_ready", {63'h0, in_ready}, 64'h0);
        chk("bp_C_main_holds_A", out_wb_data, 64'hA);
        chk("bp_C_rd_holds_A", {59'h0, out_rd}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_out_B", out_wb_data, 64'hB);
        chk("bp_out_B_in_ready", {63'h0, in_ready}, 64'h1);
        tick();
        chk("bp_out_C", out_wb_data, 64'hC);
        chk("bp_out_C_valid", {63'h0, out_valid}, 64'h1);
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_no_dup", {63'h0, out_valid}, 64'h0);
        chk("bp_stall_count", {48'h0, stall_cycles}, 64'd2);

        // Flush while in TWO with a new input offered the same cycle
        drive(1'b1, 64'h0, 64'hD, 5'd4, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h0, 64'hE, 5'd5, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fl_two_in_ready", {63'h0, in_ready}, 64'h0);
        drive(1'b1, 64'h0, 64'h6, 5'd6, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", {63'h0, out_valid}, 64'h0);
        chk("fl_in_ready", {63'h0, in_ready}, 64'h1);
        chk("fl_stall_kept", {48'h0, stall_cycles}, 64'd4);
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("fl_dropped_stays_empty", {63'h0, out_valid}, 64'h0);
        drive(1'b1, 64'h0, 64'h88, 5'd8, 1'b0, 1'b1, 1'b1);
        tick();
        chk("fl_next_is_new", out_wb_data, 64'h88);
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("fl_after_new_empty", {63'h0, out_valid}, 64'h0);

        // Async reset mid-cycle while in TWO
        drive(1'b1, 64'h0, 64'h111, 5'd10, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64'h0, 64'h222, 5'd11, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ar_pre_in_ready", {63'h0, in_ready}, 64'h0);
        drive(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {63'h0, out_valid}, 64'h0);
        chk("ar_in_ready", {63'h0, in_ready}, 64'h1);
        chk("ar_wb_data", out_wb_data, 64'h0);
        chk("ar_rd", {59'h0, out_rd}, 64'h0);
        chk("ar_stall", {48'h0, stall_cycles}, 64'h0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ar_skid_discarded", {63'h0, out_valid}, 64'h0);

        // Saturation on the 4-bit counter instance
        in_valid2  = 1'b1;
        out_ready2 = 1'b0;
        tick();
        in_valid2 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        chk("sat_count", {60'h0, stall_cycles2}, 64'd15);
        chk("sat_valid_held", {63'h0, out_valid2}, 64'h1);
        chk("sat_data_held", out_wb_data2, 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_mem_wb_skid_reg
`default_nettype wire

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Next-generation MEM/WB pipeline register for the 64-bit RISC-V core.
- Parametrised in data width and register-address width.
- Adds a valid/ready handshake with a 2-entry skid buffer, so downstream back-pressure never drops a retiring instruction.
- Also provides synchronous flush, x0 write suppression, the registered writeback-mux result, and a saturating back-pressure stall counter.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- XLEN, 64, width of read data, ALU result and writeback data.
- REG_ADDR_W, 5, width of destination register index.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept; registered, equals (state != TWO)
- in_read_data  in  XLEN  load data from data memory
- in_aluresult  in  XLEN  ALU result / address
- in_rd  in  REG_ADDR_W  destination register
- in_memtoreg  in  1  select load data for writeback
- in_regwrite  in  1  register write enable
- out_valid  out  1  main entry holds a valid instruction
- out_ready  in  1  writeback consumer accepts this cycle
- out_readdata  out  XLEN  registered load data
- out_aluresult  out  XLEN  registered ALU result
- out_rd  out  REG_ADDR_W  registered destination
- out_memtoreg  out  1  registered select
- out_regwrite  out  1  registered write enable (already x0-masked)
- out_wb_data  out  XLEN  registered result: out_memtoreg ? out_readdata : out_aluresult
- stall_cycles  out  CNT_W  saturating count of out_valid && !out_ready cycles

Behaviour:
- Reset, asynchronous, active-high. While asserted and on release:
  - state=EMPTY; every out_* data field is 0; out_valid=0, in_ready=1.
  - Skid entry cleared; stall_cycles=0.
  - Reset mid-operation discards both entries immediately.
- Handshake terms:
  - accept = in_valid && in_ready.
  - fire = out_valid && out_ready.
  - Data fields never change while out_valid=1 and out_ready=0.
- Capture rule:
  - out_regwrite/skid regwrite is stored as in_regwrite && (in_rd != 0).
  - wb_data is computed from the incoming fields at capture time, so out_wb_data is a flop, not a combinational mux.
- State machine. Main entry drives out_*; the skid entry is internal.
  - EMPTY, in_valid: main<=in → ONE. Otherwise stay.
  - ONE, out_ready && in_valid: main<=in → ONE.
  - ONE, out_ready && !in_valid → EMPTY.
  - ONE, !out_ready && in_valid: skid<=in → TWO.
  - ONE, otherwise: hold.
  - TWO: in_ready=0, input ignored. out_ready: main<=skid → ONE. Else hold.
- Latency:
  - 1 cycle from accept to out_valid when empty.
  - Full throughput: 1 instruction/cycle with out_ready held high.
- Flush, synchronous, highest priority after reset:
  - Next state EMPTY; out_valid=0, skid invalid, in_ready=1.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - Data fields may keep stale values; stall_cycles is not cleared.
- Stall counter:
  - Increments on each clock where out_valid && !out_ready.
  - Saturates at all-ones; no wrap.
- Simultaneous fire and accept in ONE is a pass-through, not a skid fill.

Decomposition:
- Shared package core_pkg holds:
  - XLEN and REG_ADDR_W defaults.
  - The 3-value state enum {EMPTY, ONE, TWO}.
  - A packed struct wb_payload_t {readdata, aluresult, wb_data, rd, memtoreg, regwrite}, so main and skid are single registers.
- One natural sub-module: sat_counter (CNT_W wide, enable, async reset). It implements stall_cycles.

Test Plan:
1. Reset then a single stream:
   - Stimulus: in_valid=1, rd=5, aluresult=0x10, memtoreg=0, regwrite=1, out_ready=1.
   - Required: next cycle out_valid=1, out_wb_data=0x10, out_rd=5, out_regwrite=1.
2. Load select:
   - Stimulus: read_data=0xDEAD_BEEF, aluresult=0x40, memtoreg=1.
   - Required: out_wb_data=0xDEAD_BEEF, out_aluresult=0x40.
3. Back-pressure:
   - Stimulus: out_ready=0 while three back-to-back inputs A,B,C are offered.
   - Required: A in main, B in skid, in_ready=0, C held by source.
   - Then out_ready=1: outputs A,B,C on consecutive cycles with no loss or duplication.
   - stall_cycles equals the number of cycles out_ready was low with out_valid=1.
4. x0 suppression:
   - Stimulus: rd=0, regwrite=1.
   - Required: out_regwrite=0, out_valid=1.
5. Flush in TWO state, with in_valid=1 on the same cycle:
   - Required: next cycle out_valid=0, in_ready=1, the dropped input never appears at the output.
6. Async reset asserted mid-cycle while in TWO:
   - Required: outputs 0 immediately, without waiting for a clock edge.
   - Saturation: force CNT_W=4 with 20 stall cycles; stall_cycles=15.
